// File: rtl/wca_reg_byte_bridge.sv
// wca_reg_byte_bridge: turns a byte-wide host command stream into 16-bit
// register writes and 16-bit readbacks for the register core bank.
// Frame: command {rnw, addr}, then low/high data bytes (write) or two
// returned bytes low/high (read).
// Optional macro WCA_REG_BRIDGE_TIMEOUT_EN adds a stalled-frame timeout of
// TIMEOUT idle cycles in the byte-waiting states.
module wca_reg_byte_bridge #(
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 128,
    parameter int TIMEOUT  = 255
) (
    input  logic              Clock,
    input  logic              Aclr,
    input  logic              host_start,
    input  logic              host_valid,
    input  logic [7:0]        host_byte,
    output logic              host_ready,
    output logic              rd_valid,
    output logic [7:0]        rd_byte,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [15:0]       reg_data,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [15:0]       reg_q,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, WR_LO, WR_HI, WR_COMMIT, RD_REQ, RD_CAP, RD_LO, RD_HI
    } state_t;

    // Reject parameter sets the command format cannot express.
    if (ADDR_W < 1 || ADDR_W > 7 || TIMEOUT < 1) begin : g_bad_param
        $error("wca_reg_byte_bridge: ADDR_W must be 1..7 and TIMEOUT >= 1");
    end

    state_t      state;
    logic [7:0]  shadow_hi;
    logic        xfer;
    logic        rd_hs;
    logic        addr_ok;
    logic [31:0] addr_ext;
    logic        cmd_rd;
    state_t      cmd_state;
    logic        timeout_hit;

    assign xfer      = host_valid && host_ready;
    assign rd_hs     = rd_valid && rd_ready;
    assign addr_ext  = 32'(reg_addr);
    assign addr_ok   = addr_ext < 32'(NUM_REGS);
    assign cmd_rd    = host_byte[7];
    assign cmd_state = cmd_rd ? RD_REQ : WR_LO;

`ifdef WCA_REG_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             waiting;

    assign waiting     = (state == WR_LO) || (state == WR_HI) ||
                         (state == RD_LO) || (state == RD_HI);
    assign timeout_hit = waiting && !xfer && !rd_hs &&
                         (idle_cnt == CNT_W'(TIMEOUT - 1));

    // Count idle cycles while a frame waits on the host; any handshake restarts it.
    always_ff @(posedge Clock or posedge Aclr) begin
        if (Aclr) begin
            idle_cnt <= '0;
        end else if (!waiting || xfer || rd_hs || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Frame sequencer with registered strobes, handshakes and readback byte.
    always_ff @(posedge Clock or posedge Aclr) begin
        if (Aclr) begin
            state      <= IDLE;
            host_ready <= 1'b1;
            rd_valid   <= 1'b0;
            rd_byte    <= 8'h00;
            reg_addr   <= '0;
            reg_data   <= 16'h0000;
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            err        <= 1'b0;
            shadow_hi  <= 8'h00;
        end else begin
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            err       <= 1'b0;
            if (timeout_hit) begin
                state      <= IDLE;
                host_ready <= 1'b1;
                rd_valid   <= 1'b0;
                err        <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (xfer) begin
                            if (host_start) begin
                                reg_addr   <= host_byte[ADDR_W-1:0];
                                state      <= cmd_state;
                                reg_rd_en  <= cmd_rd;
                                host_ready <= !cmd_rd;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    WR_LO: begin
                        if (xfer) begin
                            if (host_start) begin
                                err        <= 1'b1;
                                reg_addr   <= host_byte[ADDR_W-1:0];
                                state      <= cmd_state;
                                reg_rd_en  <= cmd_rd;
                                host_ready <= !cmd_rd;
                            end else begin
                                reg_data[7:0] <= host_byte;
                                state         <= WR_HI;
                            end
                        end
                    end
                    WR_HI: begin
                        if (xfer) begin
                            if (host_start) begin
                                err        <= 1'b1;
                                reg_addr   <= host_byte[ADDR_W-1:0];
                                state      <= cmd_state;
                                reg_rd_en  <= cmd_rd;
                                host_ready <= !cmd_rd;
                            end else begin
                                reg_data[15:8] <= host_byte;
                                state          <= WR_COMMIT;
                                host_ready     <= 1'b0;
                                reg_wr_en      <= addr_ok;
                                err            <= !addr_ok;
                            end
                        end
                    end
                    WR_COMMIT: begin
                        state      <= IDLE;
                        host_ready <= 1'b1;
                    end
                    RD_REQ: begin
                        state <= RD_CAP;
                    end
                    RD_CAP: begin
                        shadow_hi <= addr_ok ? reg_q[15:8] : 8'h00;
                        rd_byte   <= addr_ok ? reg_q[7:0] : 8'h00;
                        rd_valid  <= 1'b1;
                        err       <= !addr_ok;
                        state     <= RD_LO;
                    end
                    RD_LO: begin
                        if (rd_ready) begin
                            rd_byte <= shadow_hi;
                            state   <= RD_HI;
                        end
                    end
                    RD_HI: begin
                        if (rd_ready) begin
                            rd_valid   <= 1'b0;
                            state      <= IDLE;
                            host_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        host_ready <= 1'b1;
                        rd_valid   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
